reg_scoreboard: RTL and testbench
=================================

// Module: reg_scoreboard
// PURPOSE
//  Issue-side controller for the 32x32 register file: tracks outstanding writes per
//  architectural register and stalls instruction issue on RAW hazards and counter saturation.
//  Sits between decode (issue request) and the write-back stage that drives the regfile write port.
//  Supplies the busy mask and stall statistics to the pipeline control / debug logic.
// PARAMETERS
//  NUM_REGS     32  architectural registers; x0 is hard-wired zero, never pending
//  ADDR_W       5   register index width, equal to clog2(NUM_REGS)
//  MAX_PEND     3   max outstanding writes per register (WAW depth)
//  CNT_W        2   pending-counter width; must hold MAX_PEND
//  STALL_CNT_W  32  stall-cycle statistic width
// PORTS
//  clock          in   1            single clock, rising edge
//  reset          in   1            synchronous, active-high
//  issue_valid    in   1            decode presents an instruction
//  issue_rs1      in   ADDR_W       source 1 index
//  issue_rs2      in   ADDR_W       source 2 index
//  issue_use_rs1  in   1            instruction reads rs1
//  issue_use_rs2  in   1            instruction reads rs2
//  issue_rd       in   ADDR_W       destination index
//  issue_wr_rd    in   1            instruction writes rd
//  issue_ready    out  1            issue may proceed this cycle (combinational)
//  wb_valid       in   1            write-back commits a value this cycle (regWrite)
//  wb_rd          in   ADDR_W       committed destination index
//  flush          in   1            pipeline flush: all in-flight writes are cancelled
//  busy_mask      out  NUM_REGS     bit r = 1 while pend_cnt[r] != 0 (registered)
//  stall_cycles   out  STALL_CNT_W  saturating count of issue_valid && !issue_ready cycles
//  wb_underflow   out  1            sticky: write-back arrived for a register with zero pending
// BEHAVIOUR
//  State: pend_cnt[r] (CNT_W) per register. pend_cnt[0] is held at 0.
//  Reset: all pend_cnt=0, busy_mask=0, stall_cycles=0, wb_underflow=0. issue_ready=1 after reset.
//  Hazard terms, all from registered state only:
//   raw1 = issue_use_rs1 && rs1!=0 && pend_cnt[rs1]!=0. raw2 is the same for rs2.
//   waw_full = issue_wr_rd && rd!=0 && pend_cnt[rd]==MAX_PEND.
//   issue_ready = !(raw1 || raw2 || waw_full). It does not depend on issue_valid.
//  No same-cycle bypass: a write-back in cycle N clears a hazard starting in cycle N+1.
//   This matches regfile read timing.
//  fire = issue_valid && issue_ready.
//  Per-register update, where inc = fire&&issue_wr_rd&&rd==r and dec = wb_valid&&wb_rd==r, r!=0:
//   inc&&!dec: +1.  !inc&&dec: -1.  Both asserted: unchanged.  Neither: unchanged.
//   dec with cnt==0 and no inc: cnt stays 0 and wb_underflow is set. Only reset clears it.
//  Writes to x0 (issue or wb) are ignored and never flag underflow.
//  flush: highest priority below reset. In the same cycle, all pend_cnt become 0.
//   The same-cycle issue and wb are discarded.
//   A wb arriving after flush for a zeroed register sets wb_underflow.
//   The pipeline must kill such writes.
//  stall_cycles: +1 each cycle with issue_valid && !issue_ready. It saturates at all-ones.
//   flush does not change it.
//  busy_mask: registered image of (pend_cnt!=0), updated with the counters.
//   It has 1-cycle latency vs. the issue/wb event.
// STRUCTURE
//  The shared package riscv_regfile_pkg holds:
//   NUM_REGS, ADDR_W, REG_ZERO (5'd0), and the pend_cnt_t typedef.
//  Sub-module sb_pend_counter: one up/down saturating counter with clear and underflow flag.
//   It is instantiated NUM_REGS-1 times via generate.
//  Top level: hazard compare, fire/inc/dec decode, statistics counter.
// TESTING
//  1. Reset, then issue rd=5 with wr=1. Next cycle, issue rs1=5, use=1:
//     issue_ready=0, busy_mask[5]=1. Then wb_rd=5: ready=1 one cycle later.
//  2. Issue rd=0, then rs1=0 use=1: never stalls. busy_mask stays 0. Then wb_rd=0: no underflow.
//  3. Three issues with rd=7 (cnt=3). Fourth issue rd=7: ready=0.
//     One wb_rd=7 -> cnt=2, and the fourth issues next cycle.
//  4. Same cycle: issue rd=9 and wb_rd=9 with cnt=1 -> cnt stays 1, busy_mask[9]=1.
//  5. cnt[3]=2, assert flush together with issue rd=4 -> all cnt=0, issue discarded.
//     A later wb_rd=3 sets wb_underflow=1.
//  6. Hold a RAW stall for 10 cycles with issue_valid=1 -> stall_cycles=10.
//     Preload STALL_CNT_W=4 with 15 stall cycles -> the count saturates at 15.

Source files
------------

// File: rtl/riscv_regfile_pkg.sv
// Shared register-file constants and types.
// Used by the issue scoreboard and its pending counters.
package riscv_regfile_pkg;
   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = 5;
   localparam int CNT_W    = 2;
   localparam int MAX_PEND = 3;

   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef logic [CNT_W-1:0] pend_cnt_t;

   localparam pend_cnt_t CNT_MAX = pend_cnt_t'(MAX_PEND);
endpackage

// File: rtl/sb_pend_counter.sv
// Per-register outstanding-write counter.
// Saturating up/down count, clear, and underflow event.
module sb_pend_counter
   import riscv_regfile_pkg::*;
(
   input  logic      clock,
   input  logic      reset,
   input  logic      clear,
   input  logic      inc,
   input  logic      dec,
   output pend_cnt_t cnt,
   output logic      busy,
   output logic      udf
);

   pend_cnt_t nxt;

   always_comb begin
      nxt = cnt;
      udf = 1'b0;
      if (inc && !dec) begin
         if (cnt != CNT_MAX)
            nxt = cnt + 1'b1;
      end else if (!inc && dec) begin
         if (cnt == '0)
            udf = 1'b1;
         else
            nxt = cnt - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         cnt  <= '0;
         busy <= 1'b0;
      end else begin
         cnt  <= nxt;
         busy <= (nxt != '0);
      end
   end

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-side register scoreboard.
// Stalls issue on RAW hazards and full WAW depth.
module reg_scoreboard
   import riscv_regfile_pkg::*;
#(
   parameter int STALL_CNT_W = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   issue_valid,
   input  logic [ADDR_W-1:0]      issue_rs1,
   input  logic [ADDR_W-1:0]      issue_rs2,
   input  logic                   issue_use_rs1,
   input  logic                   issue_use_rs2,
   input  logic [ADDR_W-1:0]      issue_rd,
   input  logic                   issue_wr_rd,
   output logic                   issue_ready,
   input  logic                   wb_valid,
   input  logic [ADDR_W-1:0]      wb_rd,
   input  logic                   flush,
   output logic [NUM_REGS-1:0]    busy_mask,
   output logic [STALL_CNT_W-1:0] stall_cycles,
   output logic                   wb_underflow
);

   pend_cnt_t           cnt [NUM_REGS];
   logic [NUM_REGS-1:0] udf;
   logic                raw1;
   logic                raw2;
   logic                waw_full;
   logic                fire;

   assign cnt[0]       = '0;
   assign udf[0]       = 1'b0;
   assign busy_mask[0] = 1'b0;

   // Hazards look only at registered counts: no wb bypass.
   assign raw1 = issue_use_rs1 && issue_rs1 != REG_ZERO
              && cnt[issue_rs1] != '0;
   assign raw2 = issue_use_rs2 && issue_rs2 != REG_ZERO
              && cnt[issue_rs2] != '0;
   assign waw_full = issue_wr_rd && issue_rd != REG_ZERO
                  && cnt[issue_rd] == CNT_MAX;

   assign issue_ready = !(raw1 || raw2 || waw_full);
   assign fire        = issue_valid && issue_ready;

   for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
      logic inc;
      logic dec;

      assign inc = fire && issue_wr_rd
                && issue_rd == ADDR_W'(r);
      assign dec = wb_valid && wb_rd == ADDR_W'(r);

      sb_pend_counter u_cnt (
         .clock (clock),
         .reset (reset),
         .clear (flush),
         .inc   (inc),
         .dec   (dec),
         .cnt   (cnt[r]),
         .busy  (busy_mask[r]),
         .udf   (udf[r])
      );
   end

   always_ff @(posedge clock) begin
      if (reset)
         wb_underflow <= 1'b0;
      else if (!flush && |udf)
         wb_underflow <= 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset)
         stall_cycles <= '0;
      else if (issue_valid && !issue_ready
               && stall_cycles != '1)
         stall_cycles <= stall_cycles + 1'b1;
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard.
// A second 4-bit-statistic instance covers saturation.
module tb_reg_scoreboard;
   import riscv_regfile_pkg::*;

   logic                clock = 1'b0;
   logic                reset;
   logic                issue_valid;
   logic [ADDR_W-1:0]   issue_rs1;
   logic [ADDR_W-1:0]   issue_rs2;
   logic                issue_use_rs1;
   logic                issue_use_rs2;
   logic [ADDR_W-1:0]   issue_rd;
   logic                issue_wr_rd;
   logic                wb_valid;
   logic [ADDR_W-1:0]   wb_rd;
   logic                flush;
   logic                issue_ready;
   logic [NUM_REGS-1:0] busy_mask;
   logic [31:0]         stall_cycles;
   logic                wb_underflow;
   logic                s_ready;
   logic [NUM_REGS-1:0] s_busy;
   logic [3:0]          s_stall;
   logic                s_udf;

   int vectors = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   reg_scoreboard dut (
      .clock         (clock),
      .reset         (reset),
      .issue_valid   (issue_valid),
      .issue_rs1     (issue_rs1),
      .issue_rs2     (issue_rs2),
      .issue_use_rs1 (issue_use_rs1),
      .issue_use_rs2 (issue_use_rs2),
      .issue_rd      (issue_rd),
      .issue_wr_rd   (issue_wr_rd),
      .issue_ready   (issue_ready),
      .wb_valid      (wb_valid),
      .wb_rd         (wb_rd),
      .flush         (flush),
      .busy_mask     (busy_mask),
      .stall_cycles  (stall_cycles),
      .wb_underflow  (wb_underflow)
   );

   reg_scoreboard #(.STALL_CNT_W(4)) dut4 (
      .clock         (clock),
      .reset         (reset),
      .issue_valid   (issue_valid),
      .issue_rs1     (issue_rs1),
      .issue_rs2     (issue_rs2),
      .issue_use_rs1 (issue_use_rs1),
      .issue_use_rs2 (issue_use_rs2),
      .issue_rd      (issue_rd),
      .issue_wr_rd   (issue_wr_rd),
      .issue_ready   (s_ready),
      .wb_valid      (wb_valid),
      .wb_rd         (wb_rd),
      .flush         (flush),
      .busy_mask     (s_busy),
      .stall_cycles  (s_stall),
      .wb_underflow  (s_udf)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      issue_valid   = 1'b0;
      issue_rs1     = '0;
      issue_rs2     = '0;
      issue_use_rs1 = 1'b0;
      issue_use_rs2 = 1'b0;
      issue_rd      = '0;
      issue_wr_rd   = 1'b0;
      wb_valid      = 1'b0;
      wb_rd         = '0;
      flush         = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic issue_wr(input logic [ADDR_W-1:0] rd);
      idle();
      issue_valid = 1'b1;
      issue_rd    = rd;
      issue_wr_rd = 1'b1;
   endtask

   task automatic issue_rd1(input logic [ADDR_W-1:0] rs);
      idle();
      issue_valid   = 1'b1;
      issue_rs1     = rs;
      issue_use_rs1 = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      vectors++;
      if (busy_mask !== 32'h0 || stall_cycles !== 32'd0
          || wb_underflow !== 1'b0 || issue_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset: busy=%h stall=%0d udf=%b rdy=%b want 0/0/0/1",
                  busy_mask, stall_cycles, wb_underflow, issue_ready);
      end
   endtask

   task automatic test_raw();
      do_reset();
      issue_wr(5'd5);
      tick();
      issue_rd1(5'd5);
      #1;
      vectors++;
      if (issue_ready !== 1'b0 || busy_mask !== 32'h20) begin
         miscompares++;
         $display("FAIL raw_stall: rdy=%b busy=%h want 0/00000020",
                  issue_ready, busy_mask);
      end
      wb_valid = 1'b1;
      wb_rd    = 5'd5;
      #1;
      vectors++;
      if (issue_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL raw_no_bypass: rdy=%b want 0", issue_ready);
      end
      tick();
      wb_valid = 1'b0;
      #1;
      vectors++;
      if (issue_ready !== 1'b1 || busy_mask !== 32'h0) begin
         miscompares++;
         $display("FAIL raw_clear: rdy=%b busy=%h want 1/0",
                  issue_ready, busy_mask);
      end
   endtask

   task automatic test_x0();
      do_reset();
      issue_wr(5'd0);
      #1;
      vectors++;
      if (issue_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL x0_wr_ready: rdy=%b want 1", issue_ready);
      end
      tick();
      issue_rd1(5'd0);
      #1;
      vectors++;
      if (issue_ready !== 1'b1 || busy_mask !== 32'h0) begin
         miscompares++;
         $display("FAIL x0_read: rdy=%b busy=%h want 1/0",
                  issue_ready, busy_mask);
      end
      tick();
      idle();
      wb_valid = 1'b1;
      wb_rd    = 5'd0;
      tick();
      idle();
      vectors++;
      if (wb_underflow !== 1'b0 || busy_mask !== 32'h0) begin
         miscompares++;
         $display("FAIL x0_wb: udf=%b busy=%h want 0/0",
                  wb_underflow, busy_mask);
      end
   endtask

   task automatic test_waw();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         issue_wr(5'd7);
         #1;
         vectors++;
         if (issue_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL waw_fill%0d: rdy=%b want 1", i, issue_ready);
         end
         tick();
      end
      #1;
      vectors++;
      if (issue_ready !== 1'b0 || busy_mask !== 32'h80) begin
         miscompares++;
         $display("FAIL waw_full: rdy=%b busy=%h want 0/00000080",
                  issue_ready, busy_mask);
      end
      wb_valid = 1'b1;
      wb_rd    = 5'd7;
      tick();
      wb_valid = 1'b0;
      #1;
      vectors++;
      if (issue_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL waw_drain1: rdy=%b want 1", issue_ready);
      end
      tick();
      #1;
      vectors++;
      if (issue_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL waw_refull: rdy=%b want 0", issue_ready);
      end
      idle();
      wb_valid = 1'b1;
      wb_rd    = 5'd7;
      tick();
      tick();
      tick();
      idle();
      vectors++;
      if (busy_mask !== 32'h0 || wb_underflow !== 1'b0) begin
         miscompares++;
         $display("FAIL waw_empty: busy=%h udf=%b want 0/0",
                  busy_mask, wb_underflow);
      end
   endtask

   task automatic test_inc_dec();
      do_reset();
      issue_wr(5'd9);
      tick();
      issue_wr(5'd9);
      wb_valid = 1'b1;
      wb_rd    = 5'd9;
      tick();
      idle();
      vectors++;
      if (busy_mask !== 32'h200) begin
         miscompares++;
         $display("FAIL incdec_busy: busy=%h want 00000200", busy_mask);
      end
      wb_valid = 1'b1;
      wb_rd    = 5'd9;
      tick();
      vectors++;
      if (busy_mask !== 32'h0 || wb_underflow !== 1'b0) begin
         miscompares++;
         $display("FAIL incdec_cnt1: busy=%h udf=%b want 0/0",
                  busy_mask, wb_underflow);
      end
      tick();
      idle();
      vectors++;
      if (wb_underflow !== 1'b1) begin
         miscompares++;
         $display("FAIL underflow: udf=%b want 1", wb_underflow);
      end
   endtask

   task automatic test_flush();
      do_reset();
      issue_wr(5'd3);
      tick();
      tick();
      issue_wr(5'd4);
      flush = 1'b1;
      tick();
      idle();
      vectors++;
      if (busy_mask !== 32'h0 || wb_underflow !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_clear: busy=%h udf=%b want 0/0",
                  busy_mask, wb_underflow);
      end
      issue_rd1(5'd4);
      #1;
      vectors++;
      if (issue_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_discard: rdy=%b want 1", issue_ready);
      end
      idle();
      wb_valid = 1'b1;
      wb_rd    = 5'd3;
      tick();
      idle();
      vectors++;
      if (wb_underflow !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_udf: udf=%b want 1", wb_underflow);
      end
   endtask

   task automatic test_stall();
      do_reset();
      issue_wr(5'd2);
      tick();
      issue_rd1(5'd2);
      for (int i = 0; i < 10; i++)
         tick();
      vectors++;
      if (stall_cycles !== 32'd10 || s_stall !== 4'd10) begin
         miscompares++;
         $display("FAIL stall10: cnt=%0d cnt4=%0d want 10/10",
                  stall_cycles, s_stall);
      end
      for (int i = 0; i < 10; i++)
         tick();
      vectors++;
      if (stall_cycles !== 32'd20 || s_stall !== 4'd15) begin
         miscompares++;
         $display("FAIL stall_sat: cnt=%0d cnt4=%0d want 20/15",
                  stall_cycles, s_stall);
      end
      idle();
      flush = 1'b1;
      tick();
      idle();
      tick();
      vectors++;
      if (stall_cycles !== 32'd20 || busy_mask !== 32'h0) begin
         miscompares++;
         $display("FAIL stall_flush: cnt=%0d busy=%h want 20/0",
                  stall_cycles, busy_mask);
      end
   endtask

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_raw();
      test_x0();
      test_waw();
      test_inc_dec();
      test_flush();
      test_stall();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
